pwm_scheduler: RTL
==================

PWM_SCHEDULER -- requirements
Module: pwm_scheduler

Interface
REQ-001 SHALL have parameter bitwidth, default 10, width of counter, period and edge values.
REQ-002 SHALL have parameter channels, default 4, number of pulse channels scheduled (1..8).
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  run counter when high.
REQ-006 SHALL have port wr_valid  input  1  edge-write request.
REQ-007 SHALL have port wr_ready  output  1  edge-write accept.
REQ-008 SHALL have port wr_channel  input  3  target channel index.
REQ-009 SHALL have port wr_rising  input  bitwidth  rising-edge tick for target channel.
REQ-010 SHALL have port wr_falling  input  bitwidth  falling-edge tick for target channel.
REQ-011 SHALL have port commit  input  1  request atomic update of all channels.
REQ-012 SHALL have port commit_period  input  bitwidth  new last counter value, sampled with commit.
REQ-013 SHALL have port counter  output  bitwidth  shared timebase for pulse instances.
REQ-014 SHALL have port rising_edges  output  channels*bitwidth  active rising ticks, channel 0 in LSBs.
REQ-015 SHALL have port falling_edges  output  channels*bitwidth  active falling ticks, channel 0 in LSBs.
REQ-016 SHALL have port period_start  output  1  one-cycle strobe, first cycle of each period.
REQ-017 SHALL have port update_done  output  1  one-cycle strobe, commit applied.

Function
REQ-018 SHALL count 0..active period, wrapping to 0 after the cycle counter equals active period; active period 0 yields a wrap every cycle.
REQ-019 SHALL hold counter at 0 and generate no wraps while enable is low.
REQ-020 SHALL write shadow[wr_channel] on wr_valid && wr_ready; wr_channel >= channels is accepted and discarded.
REQ-021 SHALL drive wr_ready low exactly while a commit is pending; wr_ready is high otherwise.
REQ-022 SHALL, on commit while not pending, capture commit_period and set pending; commit while pending is ignored.
REQ-023 SHALL, at the wrap clock edge with pending set, load all active edges and active period from shadow, clear pending, and assert update_done in the cycle counter shows 0.
REQ-024 SHALL, with pending set and enable low, apply the update on the next clock edge.
REQ-025 SHALL, on write and commit in the same cycle, include that write in the committed set.
REQ-026 SHALL, on commit arriving in a wrap cycle, apply it at the following wrap, not the current one.
REQ-027 SHALL assert period_start registered, in each cycle counter shows 0 after a wrap while enable is high.
REQ-028 SHALL pass edge values unchecked; values above active period are legal and forwarded unchanged.
REQ-029 SHALL change rising_edges/falling_edges only at the edge where counter becomes 0 or under REQ-024.

Reset
REQ-030 SHALL on reset low: counter 0, active and shadow edges 0, active period all-ones, pending 0, wr_ready 1, period_start 0, update_done 0.
REQ-031 SHALL discard a pending commit and any in-flight write when reset asserts mid-period.

Configuration
REQ-032 SHALL, with PWM_SCHEDULER_IRQ_EN defined, add output irq (1 bit) and input irq_clear (1 bit); irq sets on update_done, clears on irq_clear, set wins if simultaneous, resets to 0.
REQ-033 SHALL, without PWM_SCHEDULER_IRQ_EN, omit irq and irq_clear ports and logic entirely.

Verification
REQ-034 SHALL cover: reset, enable=1, no commit -> counter 0..1023 wraps to 0, all edge outputs 0, period_start every 1024 cycles.
REQ-035 SHALL cover: write ch1 rising=10 falling=20, commit period=99 at counter 500 -> wr_ready low until wrap, ch1 edges 10/20 and period 99 visible when counter shows 0, update_done one cycle.
REQ-036 SHALL cover: commit period=0 -> after apply, counter constant 0, period_start every cycle.
REQ-037 SHALL cover: enable=0, write ch3 5/7, commit -> applied next cycle, counter stays 0, no period_start.
REQ-038 SHALL cover: second commit while pending, write with wr_channel=6 (channels=4) -> ignored, no shadow change; reset low mid-period -> all outputs to REQ-030 values immediately.
REQ-039 SHALL cover with PWM_SCHEDULER_IRQ_EN: update_done and irq_clear same cycle -> irq stays 1; irq_clear alone -> irq 0 next cycle.

Source files
------------

// File: rtl/pwm_scheduler.sv
// Shared PWM timebase with shadowed per-channel edge ticks, swapped atomically at the period wrap.
// Latency: a commit lands at the next wrap edge (next edge if enable is low); update_done follows one cycle later.
// Backpressure: wr_ready drops while a commit is pending; optional irq output under PWM_SCHEDULER_IRQ_EN.
module pwm_scheduler #(
    parameter int bitwidth = 10,
    parameter int channels = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [2:0]                   wr_channel,
    input  logic [bitwidth-1:0]          wr_rising,
    input  logic [bitwidth-1:0]          wr_falling,
    input  logic                         commit,
    input  logic [bitwidth-1:0]          commit_period,
    output logic [bitwidth-1:0]          counter,
    output logic [channels*bitwidth-1:0] rising_edges,
    output logic [channels*bitwidth-1:0] falling_edges,
    output logic                         period_start,
    output logic                         update_done
`ifdef PWM_SCHEDULER_IRQ_EN
    ,
    output logic                         irq,
    input  logic                         irq_clear
`endif
);

    logic                pending;
    logic [bitwidth-1:0] shadow_period;
    logic [bitwidth-1:0] active_period;
    logic                wrap;
    logic                apply;
    logic                wr_fire;
    logic                commit_fire;

    // A disabled timer has no wraps, so a pending update must not wait for one.
    assign wrap        = enable && (counter == active_period);
    assign apply       = pending && (wrap || !enable);
    assign wr_ready    = !pending;
    assign wr_fire     = wr_valid && wr_ready;
    assign commit_fire = commit && !pending;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter <= '0;
        end else if (!enable || wrap) begin
            counter <= '0;
        end else begin
            counter <= counter + bitwidth'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending       <= 1'b0;
            shadow_period <= '1;
            active_period <= '1;
            period_start  <= 1'b0;
            update_done   <= 1'b0;
        end else begin
            period_start <= wrap;
            update_done  <= apply;
            // apply needs pending set and commit_fire needs it clear, so they never collide.
            if (apply) begin
                pending       <= 1'b0;
                active_period <= shadow_period;
            end else if (commit_fire) begin
                pending       <= 1'b1;
                shadow_period <= commit_period;
            end
        end
    end

    for (genvar ch = 0; ch < channels; ch++) begin : g_ch
        logic [bitwidth-1:0] shadow_rise;
        logic [bitwidth-1:0] shadow_fall;
        logic [bitwidth-1:0] active_rise;
        logic [bitwidth-1:0] active_fall;
        logic                sel;

        // Indices at or above channels match no slot, so those writes vanish.
        assign sel = wr_fire && (wr_channel == 3'(ch));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                shadow_rise <= '0;
                shadow_fall <= '0;
                active_rise <= '0;
                active_fall <= '0;
            end else begin
                if (sel) begin
                    shadow_rise <= wr_rising;
                    shadow_fall <= wr_falling;
                end
                if (apply) begin
                    active_rise <= shadow_rise;
                    active_fall <= shadow_fall;
                end
            end
        end

        assign rising_edges[ch*bitwidth +: bitwidth]  = active_rise;
        assign falling_edges[ch*bitwidth +: bitwidth] = active_fall;
    end

`ifdef PWM_SCHEDULER_IRQ_EN
    // A fresh update outranks a clear landing on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (update_done) begin
            irq <= 1'b1;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule
